// File: rtl/rvfi_regfile_check.sv
// RVFI register-file consistency monitor: shadows architectural registers from retirement
// traces, checks source reads and retirement order, and latches the first error seen.
module rvfi_regfile_check #(
  parameter int unsigned NRET        = 1,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ORDER_W     = 64,
  parameter bit          ZERO_INIT   = 1'b0,
  parameter bit          CHECK_X0    = 1'b1,
  parameter bit          CHECK_ORDER = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*5-1:0]       rvfi_rs1_addr,
  input  logic [NRET*5-1:0]       rvfi_rs2_addr,
  input  logic [NRET*5-1:0]       rvfi_rd,
  input  logic [NRET*XLEN-1:0]    rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]    rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0]    rvfi_post_rd,
  output logic                    err,
  output logic [2:0]              err_code,
  output logic [2:0]              err_channel,
  output logic [ORDER_W-1:0]      err_order,
  output logic [31:0]             retired_count
);

  localparam int unsigned NREG = 32;
  localparam int unsigned CNT_W = 32;
  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_ORDER = 3'd1;
  localparam logic [2:0] CODE_RS1   = 3'd2;
  localparam logic [2:0] CODE_RS2   = 3'd3;
  localparam logic [2:0] CODE_X0    = 3'd4;
  localparam logic [NREG-1:0] WR_INIT = ZERO_INIT ? {NREG{1'b1}} : {31'd0, CHECK_X0};

  logic [XLEN-1:0]    shadow [NREG];
  logic [NREG-1:0]    written;
  logic               order_valid;
  logic [ORDER_W-1:0] order_next;

  logic [XLEN-1:0]    shadow_c [NREG];
  logic [NREG-1:0]    written_c;
  logic               order_valid_c;
  logic [ORDER_W-1:0] order_next_c;
  logic               hit_c;
  logic [2:0]         code_c;
  logic [2:0]         chan_c;
  logic [ORDER_W-1:0] eorder_c;
  logic [2:0]         ch_code_c;
  logic [3:0]         pop_c;
  logic [CNT_W:0]     cnt_sum_c;

  // Walk valid channels in ascending order so later channels see earlier writes.
  always_comb begin
    shadow_c      = shadow;
    written_c     = written;
    order_valid_c = order_valid;
    order_next_c  = order_next;
    hit_c         = 1'b0;
    code_c        = CODE_NONE;
    chan_c        = 3'd0;
    eorder_c      = '0;
    ch_code_c     = CODE_NONE;
    pop_c         = 4'd0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        ch_code_c = CODE_NONE;
        // Assigned highest code first so the lowest applicable code wins.
        if (CHECK_X0 && rvfi_rd[i*5 +: 5] == 5'd0 && rvfi_post_rd[i*XLEN +: XLEN] != '0)
          ch_code_c = CODE_X0;
        if (written_c[rvfi_rs2_addr[i*5 +: 5]] &&
            shadow_c[rvfi_rs2_addr[i*5 +: 5]] != rvfi_pre_rs2[i*XLEN +: XLEN])
          ch_code_c = CODE_RS2;
        if (written_c[rvfi_rs1_addr[i*5 +: 5]] &&
            shadow_c[rvfi_rs1_addr[i*5 +: 5]] != rvfi_pre_rs1[i*XLEN +: XLEN])
          ch_code_c = CODE_RS1;
        if (CHECK_ORDER && order_valid_c && rvfi_order[i*ORDER_W +: ORDER_W] != order_next_c)
          ch_code_c = CODE_ORDER;
        if (!hit_c && ch_code_c != CODE_NONE) begin
          hit_c    = 1'b1;
          code_c   = ch_code_c;
          chan_c   = 3'(i);
          eorder_c = rvfi_order[i*ORDER_W +: ORDER_W];
        end
        order_valid_c = 1'b1;
        order_next_c  = rvfi_order[i*ORDER_W +: ORDER_W] + ORDER_W'(1);
        if (!(CHECK_X0 && rvfi_rd[i*5 +: 5] == 5'd0)) begin
          shadow_c[rvfi_rd[i*5 +: 5]]  = rvfi_post_rd[i*XLEN +: XLEN];
          written_c[rvfi_rd[i*5 +: 5]] = 1'b1;
        end
        pop_c = pop_c + 4'd1;
      end
    end
    cnt_sum_c = (CNT_W+1)'(retired_count) + (CNT_W+1)'(pop_c);
  end

  // Tracking state advances only on cycles with at least one retirement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) shadow[r] <= '0;
      written       <= WR_INIT;
      order_valid   <= 1'b0;
      order_next    <= '0;
      err           <= 1'b0;
      err_code      <= CODE_NONE;
      err_channel   <= 3'd0;
      err_order     <= '0;
      retired_count <= '0;
    end else if (|rvfi_valid) begin
      shadow      <= shadow_c;
      written     <= written_c;
      order_valid <= order_valid_c;
      order_next  <= order_next_c;
      if (!err && hit_c) begin
        err         <= 1'b1;
        err_code    <= code_c;
        err_channel <= chan_c;
        err_order   <= eorder_c;
      end
      retired_count <= cnt_sum_c[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Bench for rvfi_regfile_check: two instances (NRET=4 plain, NRET=2 zero-initialised) fed one
// directed stream and compared every cycle against a behavioural register-file model.
module tb_rvfi_regfile_check;

  localparam int unsigned XL = 32;
  localparam int unsigned OW = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [3:0]    v;
  logic [OW-1:0] ord_i [4];
  logic [4:0]    rs1_i [4];
  logic [4:0]    rs2_i [4];
  logic [4:0]    rd_i  [4];
  logic [XL-1:0] p1_i  [4];
  logic [XL-1:0] p2_i  [4];
  logic [XL-1:0] pr_i  [4];

  logic [4*OW-1:0] order_bus;
  logic [4*5-1:0]  rs1_bus, rs2_bus, rd_bus;
  logic [4*XL-1:0] p1_bus, p2_bus, pr_bus;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      order_bus[i*OW +: OW] = ord_i[i];
      rs1_bus[i*5 +: 5]     = rs1_i[i];
      rs2_bus[i*5 +: 5]     = rs2_i[i];
      rd_bus[i*5 +: 5]      = rd_i[i];
      p1_bus[i*XL +: XL]    = p1_i[i];
      p2_bus[i*XL +: XL]    = p2_i[i];
      pr_bus[i*XL +: XL]    = pr_i[i];
    end
  end

  logic          err_a, err_b;
  logic [2:0]    code_a, code_b, chan_a, chan_b;
  logic [OW-1:0] eord_a, eord_b;
  logic [31:0]   cnt_a, cnt_b;

  rvfi_regfile_check #(.NRET(4), .XLEN(XL), .ORDER_W(OW), .ZERO_INIT(1'b0)) dut (
    .clk(clk), .resetn(resetn), .rvfi_valid(v), .rvfi_order(order_bus),
    .rvfi_rs1_addr(rs1_bus), .rvfi_rs2_addr(rs2_bus), .rvfi_rd(rd_bus),
    .rvfi_pre_rs1(p1_bus), .rvfi_pre_rs2(p2_bus), .rvfi_post_rd(pr_bus),
    .err(err_a), .err_code(code_a), .err_channel(chan_a), .err_order(eord_a),
    .retired_count(cnt_a)
  );

  rvfi_regfile_check #(.NRET(2), .XLEN(XL), .ORDER_W(OW), .ZERO_INIT(1'b1)) dut_z (
    .clk(clk), .resetn(resetn), .rvfi_valid(v[1:0]), .rvfi_order(order_bus[2*OW-1:0]),
    .rvfi_rs1_addr(rs1_bus[9:0]), .rvfi_rs2_addr(rs2_bus[9:0]), .rvfi_rd(rd_bus[9:0]),
    .rvfi_pre_rs1(p1_bus[2*XL-1:0]), .rvfi_pre_rs2(p2_bus[2*XL-1:0]),
    .rvfi_post_rd(pr_bus[2*XL-1:0]),
    .err(err_b), .err_code(code_b), .err_channel(chan_b), .err_order(eord_b),
    .retired_count(cnt_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model; index 0 mirrors dut, index 1 mirrors dut_z.
  bit [XL-1:0] m_sh   [2][32];
  bit          m_wr   [2][32];
  bit          m_base [2];
  bit [OW-1:0] m_exp  [2];
  bit          m_err  [2];
  bit [2:0]    m_code [2];
  bit [2:0]    m_chan [2];
  bit [OW-1:0] m_eord [2];
  bit [31:0]   m_cnt  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) begin
        m_sh[m][r] = '0;
        m_wr[m][r] = (m == 1) || (r == 0);
      end
      m_base[m] = 1'b0; m_exp[m] = '0; m_err[m] = 1'b0;
      m_code[m] = '0;   m_chan[m] = '0; m_eord[m] = '0; m_cnt[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int n;
      n = (m == 0) ? 4 : 2;
      for (int c = 0; c < n; c++) begin
        if (v[c]) begin
          bit [2:0] ec;
          ec = 3'd0;
          if (m_base[m] && ord_i[c] != m_exp[m])                         ec = 3'd1;
          else if (m_wr[m][rs1_i[c]] && m_sh[m][rs1_i[c]] != p1_i[c])    ec = 3'd2;
          else if (m_wr[m][rs2_i[c]] && m_sh[m][rs2_i[c]] != p2_i[c])    ec = 3'd3;
          else if (rd_i[c] == 5'd0 && pr_i[c] != '0)                     ec = 3'd4;
          if (!m_err[m] && ec != 3'd0) begin
            m_err[m] = 1'b1; m_code[m] = ec; m_chan[m] = 3'(c); m_eord[m] = ord_i[c];
          end
          m_base[m] = 1'b1;
          m_exp[m]  = ord_i[c] + 64'd1;
          if (rd_i[c] != 5'd0) begin
            m_sh[m][rd_i[c]] = pr_i[c];
            m_wr[m][rd_i[c]] = 1'b1;
          end
          if (m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m] = m_cnt[m] + 32'd1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else         model_step();
  end

  always @(negedge clk) begin
    chk("err_a",   64'(err_a),  64'(m_err[0]));
    chk("code_a",  64'(code_a), 64'(m_code[0]));
    chk("chan_a",  64'(chan_a), 64'(m_chan[0]));
    chk("order_a", eord_a,      m_eord[0]);
    chk("count_a", 64'(cnt_a),  64'(m_cnt[0]));
    chk("err_b",   64'(err_b),  64'(m_err[1]));
    chk("code_b",  64'(code_b), 64'(m_code[1]));
    chk("chan_b",  64'(chan_b), 64'(m_chan[1]));
    chk("order_b", eord_b,      m_eord[1]);
    chk("count_b", 64'(cnt_b),  64'(m_cnt[1]));
  end

  task automatic clear();
    v = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ord_i[i] = '0; rs1_i[i] = '0; rs2_i[i] = '0; rd_i[i] = '0;
      p1_i[i] = '0;  p2_i[i] = '0;  pr_i[i] = '0;
    end
  endtask

  task automatic set_ch(input int c, input logic [OW-1:0] o,
                        input logic [4:0] a1, input logic [XL-1:0] d1,
                        input logic [4:0] a2, input logic [XL-1:0] d2,
                        input logic [4:0] r,  input logic [XL-1:0] dr);
    v[c] = 1'b1; ord_i[c] = o;
    rs1_i[c] = a1; p1_i[c] = d1; rs2_i[c] = a2; p2_i[c] = d2;
    rd_i[c] = r; pr_i[c] = dr;
  endtask

  // Inputs set before tick() are consumed at its rising edge; outputs are read 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
    clear();
  endtask

  task automatic do_reset();
    clear();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b1;
    clear();
    model_reset();
    #1 resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);

    // Write then mismatching read on a single channel.
    set_ch(0, 64'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h1234);
    tick();
    chk("s1_pre_err", 64'(err_a), 64'd0);
    set_ch(0, 64'd1, 5'd5, 32'h1235, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("s1_err",   64'(err_a),  64'd1);
    chk("s1_code",  64'(code_a), 64'd2);
    chk("s1_chan",  64'(chan_a), 64'd0);
    chk("s1_order", eord_a,      64'd1);
    chk("s1_code_z", 64'(code_b), 64'd2);

    // Same-cycle forwarding from channel 0 to channel 1.
    do_reset();
    set_ch(0, 64'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hA);
    set_ch(1, 64'd1, 5'd0, 32'h0, 5'd7, 32'hA, 5'd0, 32'h0);
    tick();
    chk("s2_fwd_ok",   64'(err_a), 64'd0);
    chk("s2_fwd_ok_z", 64'(err_b), 64'd0);
    set_ch(0, 64'd2, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hA);
    set_ch(1, 64'd3, 5'd0, 32'h0, 5'd7, 32'hB, 5'd0, 32'h0);
    tick();
    chk("s2_code",  64'(code_a), 64'd3);
    chk("s2_chan",  64'(chan_a), 64'd1);
    chk("s2_order", eord_a,      64'd3);

    // Order gap, resync, and no second capture.
    do_reset();
    set_ch(0, 64'd10, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    set_ch(0, 64'd11, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s3_pre_err", 64'(err_a), 64'd0);
    set_ch(0, 64'd13, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s3_code",  64'(code_a), 64'd1);
    chk("s3_order", eord_a,      64'd13);
    set_ch(0, 64'd14, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s3_keep_order", eord_a, 64'd13);
    set_ch(0, 64'd16, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s3_sticky_order", eord_a, 64'd13);
    chk("s3_count", 64'(cnt_a), 64'd5);

    // x0 written nonzero; zero-initialised read before any write.
    do_reset();
    set_ch(0, 64'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h1); tick();
    chk("s4_x0_code",   64'(code_a), 64'd4);
    chk("s4_x0_code_z", 64'(code_b), 64'd4);
    do_reset();
    set_ch(0, 64'd0, 5'd9, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s4_zi_ok_z", 64'(err_b), 64'd0);
    set_ch(0, 64'd1, 5'd9, 32'h3, 5'd0, 32'h0, 5'd0, 32'h0); tick();
    chk("s4_unwritten_a", 64'(err_a),  64'd0);
    chk("s4_zi_code_z",   64'(code_b), 64'd2);

    // Simultaneous order (ch0) and rs1 (ch1) errors, then async reset mid-cycle.
    do_reset();
    set_ch(0, 64'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'h55);
    set_ch(1, 64'd1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    set_ch(0, 64'd5, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    set_ch(1, 64'd6, 5'd3, 32'h56, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("s5_chan",   64'(chan_a), 64'd0);
    chk("s5_code",   64'(code_a), 64'd1);
    chk("s5_order",  eord_a,      64'd5);
    chk("s5_code_z", 64'(code_b), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("s5_rst_err",   64'(err_a),  64'd0);
    chk("s5_rst_code",  64'(code_a), 64'd0);
    chk("s5_rst_chan",  64'(chan_a), 64'd0);
    chk("s5_rst_order", eord_a,      64'd0);
    chk("s5_rst_count", 64'(cnt_a),  64'd0);
    chk("s5_rst_err_z", 64'(err_b),  64'd0);
    tick();
    resetn = 1'b1;

    // Ten fully-valid cycles on four channels.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++)
        set_ch(c, 64'(4*k + c), 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
    end
    chk("s6_count",   64'(cnt_a), 64'd40);
    chk("s6_err",     64'(err_a), 64'd0);
    chk("s6_count_z", 64'(cnt_b), 64'd20);
    tick();
    chk("s6_idle_count", 64'(cnt_a), 64'd40);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_regfile_check.md
RVFI_REGFILE_CHECK -- requirements
Module: rvfi_regfile_check

Interface
REQ-001 SHALL have parameter NRET, default 1, number of retirement channels per cycle (1..8).
REQ-002 SHALL have parameter XLEN, default 32, register width (32 or 64).
REQ-003 SHALL have parameter ORDER_W, default 64, width of each rvfi_order lane.
REQ-004 SHALL have parameter ZERO_INIT, default 0; when 1, all shadow registers are valid and hold 0 out of reset.
REQ-005 SHALL have parameter CHECK_X0, default 1; when 1, x0 is permanently valid with value 0 and writes to x0 are checked.
REQ-006 SHALL have parameter CHECK_ORDER, default 1, enabling retirement-order continuity checking.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 resetn  input  1  reset, asynchronous, active-low.
REQ-009 rvfi_valid  input  NRET  per-channel retirement valid.
REQ-010 rvfi_order  input  NRET*ORDER_W  per-channel instruction index.
REQ-011 rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd  input  NRET*5 each  source and destination register indices.
REQ-012 rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_rd  input  NRET*XLEN each  source read values and destination write value.
REQ-013 err  output  1  sticky error flag.
REQ-014 err_code  output  3  first error cause: 0 none, 1 order, 2 rs1, 3 rs2, 4 x0 written nonzero.
REQ-015 err_channel  output  3  channel of first error.
REQ-016 err_order  output  ORDER_W  rvfi_order of first erroring retirement.
REQ-017 retired_count  output  32  count of valid retirements since reset, saturating at 0xFFFFFFFF.

Function
REQ-018 SHALL hold a 32-entry XLEN shadow file plus a 32-bit written vector.
REQ-019 SHALL process valid channels each cycle in ascending index; a channel sees rd updates of lower-indexed valid channels in the same cycle (same-cycle forwarding).
REQ-020 For a valid channel, if rs1 entry is written and its shadow value differs from rvfi_pre_rs1, SHALL flag code 2; likewise rs2 -> code 3.
REQ-021 Unwritten registers SHALL NOT be checked; first write to a register marks it written and loads rvfi_post_rd.
REQ-022 With CHECK_X0=1: rd=0 with rvfi_post_rd!=0 SHALL flag code 4; x0 shadow never updates; rs reads of x0 are checked against 0.
REQ-023 With CHECK_X0=0: x0 is treated as an ordinary register.
REQ-024 Several errors on one channel SHALL report lowest code; errors across channels SHALL report lowest channel.
REQ-025 With CHECK_ORDER=1: first valid channel after reset sets baseline; each subsequent valid channel (ascending index, gaps in valid allowed) SHALL have order == previous+1, else code 1.
REQ-026 On order mismatch, expected order SHALL resynchronise to the offending order value +1.
REQ-027 err, err_code, err_channel, err_order SHALL update on the clock edge after the offending input (1-cycle latency) and only while err is 0; later errors are ignored.
REQ-028 Shadow and order tracking SHALL continue updating after err is set.
REQ-029 retired_count SHALL add popcount(rvfi_valid) per cycle, saturating.
REQ-030 Cycles with rvfi_valid all-zero SHALL change no state.

Reset
REQ-031 resetn low SHALL immediately clear err, err_code, err_channel, err_order, retired_count, order baseline flag.
REQ-032 resetn low SHALL set written vector to all-ones if ZERO_INIT else all-zeros (bit 0 one if CHECK_X0), and shadow values to 0.
REQ-033 Inputs SHALL be ignored while resetn is low; reset asserted mid-run discards all tracked state.

Verification
REQ-034 NRET=1: write x5=0x1234, later read rs1=x5 pre_rs1=0x1235 -> next cycle err=1, err_code=2, err_channel=0.
REQ-035 NRET=2 same cycle: ch0 writes x7=0xA, ch1 reads rs2=x7 value 0xA -> no error; value 0xB -> err_code=3, err_channel=1.
REQ-036 Orders 10,11,13 on consecutive retirements -> err_code=1, err_order=13; subsequent 14 accepted without new capture.
REQ-037 CHECK_X0=1, rd=0 post_rd=0x1 -> err_code=4; ZERO_INIT=1, read x9=0x0 before any write -> no error, read 0x3 -> err_code=2.
REQ-038 Two simultaneous errors (ch0 order, ch1 rs1) -> err_channel=0, err_code=1; then resetn pulse low -> all outputs 0 asynchronously.
REQ-039 NRET=4, 10 cycles all valid -> retired_count=40.
